// File: rtl/motor_pkg.sv
// Shared types and constants for the motor cycle scheduler.
package motor_pkg;

  // Scheduler state encoding
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SETUP_F = 4'd1,
    FWD     = 4'd2,
    DWELL   = 4'd3,
    SETUP_B = 4'd4,
    BWD     = 4'd5,
    NEXT    = 4'd6,
    FAULT   = 4'd7
  } state_t;

  // Direction output levels
  localparam logic FW = 1'b1;
  localparam logic BW = 1'b0;

endpackage

// File: rtl/motor_cycle_sched_ir_edge_sync.sv
// Two-flop synchronizer for asynchronous active-low sensors, followed by
// single-cycle rise/fall pulse generation. All flops reset to 1 because
// the sensors idle high.
module ir_edge_sync #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] meta;
  logic [N-1:0] sync_q;
  logic [N-1:0] prev;

  // synchronizer chain plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= '1;
      sync_q <= '1;
      prev   <= '1;
    end else begin
      meta   <= din;
      sync_q <= meta;
      prev   <= sync_q;
    end
  end

  assign rise = sync_q & ~prev;
  assign fall = ~sync_q & prev;

endmodule

// File: rtl/motor_cycle_sched.sv
// Motor forward/back cycle scheduler.
// Runs a requested number of forward/dwell/backward passes between the end
// and home sensors, producing enable, direction and a divided step clock.
// Optional sensor watchdog: define MOTOR_SCHED_WDOG_EN to enable the FAULT path.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start with a non-zero cycle count
// SETUP_F | direction set forward, driver still disabled
// FWD     | driving forward until the end sensor releases
// DWELL   | driver off, waiting DLY_CYC cycles at the far end
// SETUP_B | direction set backward, driver still disabled
// BWD     | driving backward until the home sensor releases
// NEXT    | count the completed cycle, finish or start another pass
// FAULT   | sensor watchdog expired; left only by reset or abort
module motor_cycle_sched
  import motor_pkg::*;
#(
  parameter int STEP_DIV = 1000,
  parameter int DLY_CYC  = 1048576,
  parameter int TMO_CYC  = 16777216
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cycles,
  input  logic [2:0] IR,
  output logic       en,
  output logic       dir,
  output logic       step,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] cyc_cnt
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DLY_W = (DLY_CYC > 1) ? $clog2(DLY_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DLY_CYC - 1);

  state_t           state;
  logic [7:0]       cycles_q;
  logic [DLY_W-1:0] dly_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       ir_rise;
  logic [2:0]       ir_fall;
  logic             unused_sync;

`ifdef MOTOR_SCHED_WDOG_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0] wdog_cnt;
  logic             fault_q;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  ir_edge_sync #(.N(3)) u_ir_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (IR),
    .rise (ir_rise),
    .fall (ir_fall)
  );

  // mid sensor and falling edges are not used by the sequencing
  assign unused_sync = ^{ir_fall, ir_rise[1]};

  // sequencing FSM; outputs are registered alongside the state transition
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      en       <= 1'b0;
      dir      <= FW;
      busy     <= 1'b0;
      done     <= 1'b0;
      cyc_cnt  <= 8'd0;
      cycles_q <= 8'd0;
      dly_cnt  <= '0;
`ifdef MOTOR_SCHED_WDOG_EN
      wdog_cnt <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        en    <= 1'b0;
        busy  <= 1'b0;
`ifdef MOTOR_SCHED_WDOG_EN
        fault_q <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start && (cycles != 8'd0)) begin
              cycles_q <= cycles;
              cyc_cnt  <= 8'd0;
              dir      <= FW;
              busy     <= 1'b1;
              state    <= SETUP_F;
            end
          end
          SETUP_F: begin
            en    <= 1'b1;
            state <= FWD;
`ifdef MOTOR_SCHED_WDOG_EN
            wdog_cnt <= '0;
`endif
          end
          FWD: begin
            if (ir_rise[0]) begin
              en      <= 1'b0;
              dly_cnt <= DLY_LOAD;
              state   <= DWELL;
            end
`ifdef MOTOR_SCHED_WDOG_EN
            else if (wdog_cnt == TMO_LAST) begin
              en      <= 1'b0;
              busy    <= 1'b0;
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              wdog_cnt <= wdog_cnt + TMO_W'(1);
            end
`endif
          end
          DWELL: begin
            if (dly_cnt == '0) begin
              dir   <= BW;
              state <= SETUP_B;
            end else begin
              dly_cnt <= dly_cnt - DLY_W'(1);
            end
          end
          SETUP_B: begin
            en    <= 1'b1;
            state <= BWD;
`ifdef MOTOR_SCHED_WDOG_EN
            wdog_cnt <= '0;
`endif
          end
          BWD: begin
            if (ir_rise[2]) begin
              en    <= 1'b0;
              state <= NEXT;
            end
`ifdef MOTOR_SCHED_WDOG_EN
            else if (wdog_cnt == TMO_LAST) begin
              en      <= 1'b0;
              busy    <= 1'b0;
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              wdog_cnt <= wdog_cnt + TMO_W'(1);
            end
`endif
          end
          NEXT: begin
            // cycles_q is never zero here, so the count stops at the target
            cyc_cnt <= cyc_cnt + 8'd1;
            if ((cyc_cnt + 8'd1) == cycles_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              dir   <= FW;
              state <= SETUP_F;
            end
          end
          FAULT: begin
            state <= FAULT;
          end
          default: begin
            en    <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // step divider: toggles step every STEP_DIV cycles while the driver is enabled
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      div_cnt <= '0;
      step    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      step    <= ~step;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule
